address_generator_c: RTL and testbench

Write-side address generator for the systolic array output buffer; the drain-side counterpart of the A-operand read address generator. It accepts the skewed result stream leaving the bottom of the ARRAY_N columns. For each column it produces a per-lane write address and a write enable, so that row k of the result tile lands at base_addr + k in that column's output BRAM bank. It sits between the array's bottom edge and the C buffer and is started once per tile by the tile controller.

---
 rtl/address_generator_c_if.sv | 26 ++
 rtl/address_generator_c.sv | 170 +++++++++++++++++
 tb/tb_address_generator_c.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/address_generator_c_if.sv
// Tile-start / lane-write bundle between the tile controller, the C-buffer
// write generator and the output BRAM banks.
interface address_generator_c_if #(
  parameter int ADDR_WIDTH        = 16,
  parameter int ARRAY_N           = 8,
  parameter int CONCAT_ADDR_WIDTH = ADDR_WIDTH*ARRAY_N
);
  logic                         start;
  logic [ADDR_WIDTH-1:0]        base_addr;
  logic [$clog2(ARRAY_N):0]     num_rows;
  logic [7:0]                   drain_delay;
  logic [CONCAT_ADDR_WIDTH-1:0] address;
  logic [ARRAY_N-1:0]           enable;
  logic                         busy;
  logic                         done;

  modport slave (
    input  start, base_addr, num_rows, drain_delay,
    output address, enable, busy, done
  );

  modport master (
    output start, base_addr, num_rows, drain_delay,
    input  address, enable, busy, done
  );
endinterface

// File: rtl/address_generator_c.sv
// Write-side address generator for the systolic array C buffer. Follows the
// skewed result wavefront leaving the array bottom: at step t, column j
// writes row t-j to base_addr + (t-j) in its own bank.

// One output lane: enable and address for a given step.
module address_generator_c_lane #(
  parameter int LANE = 0,
  parameter int AW   = 16,
  parameter int TW   = 5,
  parameter int RW   = 4
) (
  input  logic [TW-1:0] t_i,
  input  logic [AW-1:0] base_i,
  input  logic [RW-1:0] rows_i,
  output logic          en_o,
  output logic [AW-1:0] addr_o
);
  logic [TW-1:0] diff;
  logic          ge;

  // Row index for this lane is t-LANE; valid while inside the tile.
  always_comb begin
    ge     = (t_i >= TW'(LANE));
    diff   = t_i - TW'(LANE);
    en_o   = ge && (diff < TW'(rows_i));
    addr_o = en_o ? (base_i + AW'(diff)) : '0;
  end
endmodule

module address_generator_c #(
  parameter int ADDR_WIDTH        = 16,
  parameter int ARRAY_N           = 8,
  parameter int CONCAT_ADDR_WIDTH = ADDR_WIDTH*ARRAY_N
) (
  input  logic                  clk,
  input  logic                  reset,
  address_generator_c_if.slave  bus
);
  localparam int RW = $clog2(ARRAY_N) + 1;
  localparam int TW = $clog2(ARRAY_N) + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;

  state_t                              state_q;
  logic [TW-1:0]                       t_q;
  logic [7:0]                          wcnt_q;
  logic [ADDR_WIDTH-1:0]               base_q;
  logic [RW-1:0]                       rows_q;
  logic [ARRAY_N-1:0]                  en_q;
  logic [ARRAY_N-1:0][ADDR_WIDTH-1:0]  addr_q;
  logic                                busy_q;
  logic                                done_q;

  logic [RW-1:0]                       rows_clamp;
  logic [TW-1:0]                       t_last;
  logic [TW-1:0]                       t_sel;
  logic [ADDR_WIDTH-1:0]               base_sel;
  logic [RW-1:0]                       rows_sel;
  logic [ARRAY_N-1:0]                  en_d;
  logic [ARRAY_N-1:0][ADDR_WIDTH-1:0]  addr_d;

  // Tiles taller than the array are clamped; last RUN step is R+N-2.
  always_comb begin
    rows_clamp = (bus.num_rows > RW'(ARRAY_N)) ? RW'(ARRAY_N) : bus.num_rows;
    t_last     = TW'(rows_q) + TW'(ARRAY_N - 2);
  end

  // Lanes evaluate the step being entered, so outputs land registered in
  // the same cycle as the step. From IDLE the operands come straight from
  // the start inputs since they are not latched yet.
  always_comb begin
    t_sel    = '0;
    base_sel = base_q;
    rows_sel = rows_q;
    if (state_q == IDLE) begin
      base_sel = bus.base_addr;
      rows_sel = rows_clamp;
    end else if (state_q == RUN) begin
      t_sel = t_q + TW'(1);
    end
  end

  for (genvar j = 0; j < ARRAY_N; j++) begin : g_lane
    address_generator_c_lane #(
      .LANE (j),
      .AW   (ADDR_WIDTH),
      .TW   (TW),
      .RW   (RW)
    ) u_lane (
      .t_i    (t_sel),
      .base_i (base_sel),
      .rows_i (rows_sel),
      .en_o   (en_d[j]),
      .addr_o (addr_d[j])
    );
  end

  // Tile FSM with registered lane outputs, busy and done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      wcnt_q  <= '0;
      base_q  <= '0;
      rows_q  <= '0;
      en_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            base_q <= bus.base_addr;
            rows_q <= rows_clamp;
            t_q    <= '0;
            if (rows_clamp == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (bus.drain_delay == 8'd0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              en_q    <= en_d;
              addr_q  <= addr_d;
            end else begin
              state_q <= WAIT;
              busy_q  <= 1'b1;
              wcnt_q  <= bus.drain_delay - 8'd1;
            end
          end
        end
        WAIT: begin
          if (wcnt_q == 8'd0) begin
            state_q <= RUN;
            t_q     <= '0;
            en_q    <= en_d;
            addr_q  <= addr_d;
          end else begin
            wcnt_q <= wcnt_q - 8'd1;
          end
        end
        RUN: begin
          if (t_q == t_last) begin
            state_q <= DONE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            en_q    <= '0;
            addr_q  <= '0;
          end else begin
            t_q    <= t_q + TW'(1);
            en_q   <= en_d;
            addr_q <= addr_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.address = CONCAT_ADDR_WIDTH'(addr_q);
  assign bus.enable  = en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_address_generator_c.sv
// Directed bench for address_generator_c: each tile pushes its expected
// per-cycle trace into a scoreboard, which is popped and compared cycle by
// cycle against the DUT outputs.
module tb_address_generator_c;
  localparam int AW = 16;
  localparam int N  = 8;
  localparam int CW = AW*N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  address_generator_c_if #(.ADDR_WIDTH(AW), .ARRAY_N(N)) bus ();

  address_generator_c #(.ADDR_WIDTH(AW), .ARRAY_N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [CW-1:0] addr;
    logic [N-1:0]  en;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Expected outputs in cycle c after the accepting edge.
  function automatic exp_t model(int base, int nr, int d, int c);
    exp_t e;
    int rc, t;
    e  = '0;
    rc = (nr > N) ? N : nr;
    if (rc == 0) begin
      e.done = (c == 1);
      return e;
    end
    if (c >= 1 && c <= d) begin
      e.busy = 1'b1;
    end else if (c > d && c <= d + rc + N - 1) begin
      e.busy = 1'b1;
      t = c - d - 1;
      for (int j = 0; j < N; j++) begin
        if (t >= j && (t - j) < rc) begin
          e.en[j] = 1'b1;
          e.addr[j*AW +: AW] = AW'((base + t - j) & 32'hFFFF);
        end
      end
    end else if (c == d + rc + N) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic check(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, " addr"}, bus.address, '0);
    check({tag, " en"},   CW'(bus.enable), '0);
    check({tag, " busy"}, CW'(bus.busy), '0);
    check({tag, " done"}, CW'(bus.done), '0);
  endtask

  // Run one tile. p1/p2: cycles during which start is re-pulsed (must be
  // ignored). abort_c: cycle in which reset is asserted mid-cycle (0 = none).
  task automatic run_tile(string name, int base, int nr, int d,
                          int p1, int p2, int abort_c);
    int   rc, last;
    exp_t e;
    rc   = (nr > N) ? N : nr;
    last = (rc == 0) ? 2 : d + rc + N + 1;
    for (int c = 1; c <= last; c++) sb.push_back(model(base, nr, d, c));
    bus.base_addr   = AW'(base);
    bus.num_rows    = 4'(nr);
    bus.drain_delay = 8'(d);
    bus.start       = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        // Scramble the tile inputs: the DUT must use its latched copies.
        bus.base_addr   = 16'h5A5A;
        bus.num_rows    = 4'd1;
        bus.drain_delay = 8'd7;
      end
      e = sb.pop_front();
      check($sformatf("%s c%0d addr", name, c), bus.address, e.addr);
      check($sformatf("%s c%0d en",   name, c), CW'(bus.enable), CW'(e.en));
      check($sformatf("%s c%0d busy", name, c), CW'(bus.busy), CW'(e.busy));
      check($sformatf("%s c%0d done", name, c), CW'(bus.done), CW'(e.done));
      bus.start = (c == p1) || (c == p2);
      if (c == abort_c) begin
        #2 reset = 1'b0;
        #1 check_zero({name, " async rst"});
        sb.delete();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1 check_zero($sformatf("%s rst hold %0d", name, k));
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_zero({name, " post rst"});
        return;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.base_addr   = '0;
    bus.num_rows    = '0;
    bus.drain_delay = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check_zero("idle");

    run_tile("full8",    32'h0000, 8,  0, 0, 0,  0);
    run_tile("delay2",   32'h0100, 3,  2, 0, 0,  0);
    run_tile("rows0",    32'h0040, 0,  3, 0, 0,  0);
    run_tile("rows12",   32'h0055, 12, 1, 0, 0,  0);
    // Re-starts mid-RUN (cycle 6) and in the DONE cycle (16) are ignored;
    // the following tile starts in the cycle right after done.
    run_tile("ignore",   32'h0040, 8,  0, 6, 16, 0);
    run_tile("b2b",      32'h0080, 2,  0, 0, 0,  0);
    run_tile("abort",    32'h0000, 8,  0, 0, 0,  5);
    run_tile("after",    32'h0200, 5,  1, 0, 0,  0);
    run_tile("wrap",     32'hFFFE, 4,  0, 0, 0,  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
